// File: rtl/axil_arbiter_rd_wrr_if.sv
// AXI-Lite read arbiter bundle: requests, weights, read handshake, grants.
// slave = arbiter side; master = requester/driver side.
interface axil_arbiter_rd_wrr_if #(
  parameter int NUMBER_MASTER = 4,
  parameter int WEIGHT_W      = 4
);
  localparam int IDX_W = $clog2(NUMBER_MASTER);

  logic [NUMBER_MASTER-1:0]          request_rd;
  logic [NUMBER_MASTER*WEIGHT_W-1:0] weight;
  logic                              s_axil_rvalid;
  logic [NUMBER_MASTER-1:0]          m_axil_rready;
  logic [NUMBER_MASTER-1:0]          grant_rd;
  logic [IDX_W-1:0]                  grant_idx;
  logic                              busy;

  modport slave (
    input  request_rd, weight,
    input  s_axil_rvalid, m_axil_rready,
    output grant_rd, grant_idx, busy
  );

  modport master (
    output request_rd, weight,
    output s_axil_rvalid, m_axil_rready,
    input  grant_rd, grant_idx, busy
  );
endinterface

// File: rtl/axil_arbiter_rd_wrr.sv
// AXI-Lite read arbiter: fixed / round-robin / weighted round-robin.
// Ports: aclk, areset (sync, active high), bus (slave modport:
// request_rd, weight, s_axil_rvalid, m_axil_rready in; grant_rd,
// grant_idx, busy out). With AXIL_ARB_RD_WATCHDOG_EN defined an ACKN
// watchdog is added and the timeout_err pulse output appears.
module axil_arbiter_rd_wrr #(
  parameter int NUMBER_MASTER  = 4,
  parameter int ARB_MODE       = 2,
  parameter int WEIGHT_W       = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 aclk,
  input  logic                 areset,
  axil_arbiter_rd_wrr_if.slave bus
`ifdef AXIL_ARB_RD_WATCHDOG_EN
  ,
  output logic                 timeout_err
`endif
);
  localparam int IDX_W = $clog2(NUMBER_MASTER);

  if (NUMBER_MASTER < 2 || NUMBER_MASTER > 16 ||
      ARB_MODE < 0 || ARB_MODE > 2 ||
      WEIGHT_W < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("axil_arbiter_rd_wrr: bad parameter");
  end

  typedef enum logic {IDLE, ACKN} state_t;

  state_t                   state_q, state_d;
  logic [NUMBER_MASTER-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [IDX_W-1:0]         last_q, last_d;
  logic [WEIGHT_W-1:0]      credit_q, credit_d;

  logic [NUMBER_MASTER-1:0] req;
  logic [IDX_W-1:0]         sel_lo, sel_rr, sel;
  logic [WEIGHT_W-1:0]      w_sel;
  logic                     reuse;
  logic                     hs;

`ifdef AXIL_ARB_RD_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            to_q, to_d;
  assign timeout_err = to_q;
`endif

  assign req = bus.request_rd;
  assign hs  = bus.s_axil_rvalid && bus.m_axil_rready[idx_q];

  // Descending scans: the last hit is the lowest qualifying index.
  // sel_rr falls back to the lowest requester when none is above last.
  always_comb begin
    sel_lo = '0;
    sel_rr = '0;
    for (int i = NUMBER_MASTER - 1; i >= 0; i--) begin
      if (req[i]) sel_lo = IDX_W'(i);
    end
    sel_rr = sel_lo;
    for (int i = NUMBER_MASTER - 1; i >= 0; i--) begin
      if (req[i] && IDX_W'(i) > last_q) sel_rr = IDX_W'(i);
    end
  end

  // A master that stopped requesting loses its credit here, because
  // reuse needs it requesting and the rotate path reloads credit.
  assign reuse = (ARB_MODE == 2) && req[last_q] && (credit_q != '0);

  always_comb begin
    sel = sel_rr;
    if (ARB_MODE == 0) sel = sel_lo;
    else if (reuse) sel = last_q;
  end

  assign w_sel = bus.weight[sel*WEIGHT_W +: WEIGHT_W];

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    idx_d    = idx_q;
    last_d   = last_q;
    credit_d = credit_q;
`ifdef AXIL_ARB_RD_WATCHDOG_EN
    wd_d     = wd_q;
    to_d     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (req != '0) begin
          state_d = ACKN;
          grant_d = NUMBER_MASTER'(1) << sel;
          idx_d   = sel;
          last_d  = sel;
          if (ARB_MODE == 2) begin
            if (reuse)
              credit_d = credit_q - WEIGHT_W'(1);
            else if (w_sel == '0)
              credit_d = '0;
            else
              credit_d = w_sel - WEIGHT_W'(1);
          end
`ifdef AXIL_ARB_RD_WATCHDOG_EN
          wd_d = '0;
`endif
        end
      end
      ACKN: begin
        if (hs) begin
          state_d = IDLE;
          grant_d = '0;
          idx_d   = '0;
        end
`ifdef AXIL_ARB_RD_WATCHDOG_EN
        else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state_d  = IDLE;
          grant_d  = '0;
          idx_d    = '0;
          credit_d = '0;
          to_d     = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      last_q   <= '0;
      credit_q <= '0;
`ifdef AXIL_ARB_RD_WATCHDOG_EN
      wd_q     <= '0;
      to_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      credit_q <= credit_d;
`ifdef AXIL_ARB_RD_WATCHDOG_EN
      wd_q     <= wd_d;
      to_q     <= to_d;
`endif
    end
  end

  assign bus.grant_rd  = grant_q;
  assign bus.grant_idx = idx_q;
  assign bus.busy      = (state_q == ACKN);
endmodule

// File: tb/tb_axil_arbiter_rd_wrr.sv
// Bench for axil_arbiter_rd_wrr: one instance per ARB_MODE (0,1,2),
// shared directed stimulus, per-cycle model compare plus literal checks.
module tb_axil_arbiter_rd_wrr;
  localparam int NM  = 4;
  localparam int WW  = 4;
  localparam int TOC = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] wt;
  logic        rvalid;
  logic [3:0]  rready;

  logic [3:0] g_rd [3];
  logic [1:0] g_ix [3];
  logic       g_bz [3];
`ifdef AXIL_ARB_RD_WATCHDOG_EN
  logic       to_o [3];
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 3; m++) begin : g_dut
    axil_arbiter_rd_wrr_if #(
      .NUMBER_MASTER(NM),
      .WEIGHT_W(WW)
    ) bus_if ();

    axil_arbiter_rd_wrr #(
      .NUMBER_MASTER(NM),
      .ARB_MODE(m),
      .WEIGHT_W(WW),
      .TIMEOUT_CYCLES(TOC)
    ) dut (
      .aclk(clk),
      .areset(rst),
      .bus(bus_if.slave)
`ifdef AXIL_ARB_RD_WATCHDOG_EN
      ,
      .timeout_err(to_o[m])
`endif
    );

    assign bus_if.request_rd    = req;
    assign bus_if.weight        = wt;
    assign bus_if.s_axil_rvalid = rvalid;
    assign bus_if.m_axil_rready = rready;
    assign g_rd[m] = bus_if.grant_rd;
    assign g_ix[m] = bus_if.grant_idx;
    assign g_bz[m] = bus_if.busy;
  end

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model: per instance, whether a grant is outstanding, who holds it,
  // who was granted last, remaining reuse credit, ACKN cycles spent.
  int mbusy [3];
  int mgidx [3];
  int mlast [3];
  int mcred [3];
  int mwd   [3];
  int mto   [3];
  bit mdl_ok = 1'b0;

  task automatic mdl_step(int m);
    int pick;
    int w;
    if (rst) begin
      mbusy[m] = 0; mgidx[m] = 0; mlast[m] = 0;
      mcred[m] = 0; mwd[m] = 0; mto[m] = 0;
      mdl_ok = 1'b1;
      return;
    end
    mto[m] = 0;
    if (mbusy[m] != 0) begin
      if (rvalid && rready[mgidx[m]]) begin
        mbusy[m] = 0;
        mgidx[m] = 0;
      end else begin
        mwd[m]++;
`ifdef AXIL_ARB_RD_WATCHDOG_EN
        if (mwd[m] == TOC) begin
          mto[m] = 1; mbusy[m] = 0;
          mgidx[m] = 0; mcred[m] = 0;
        end
`endif
      end
    end else if (req != 4'h0) begin
      pick = 0;
      if (m == 2 && req[mlast[m]] && mcred[m] > 0) begin
        pick = mlast[m];
        mcred[m]--;
      end else begin
        if (m == 0) begin
          for (int j = NM - 1; j >= 0; j--)
            if (req[j]) pick = j;
        end else begin
          for (int k = NM; k >= 1; k--)
            if (req[(mlast[m] + k) % NM])
              pick = (mlast[m] + k) % NM;
        end
        w = int'((wt >> (pick * WW)) & 16'hF);
        if (w == 0) w = 1;
        if (m == 2) mcred[m] = w - 1;
      end
      mbusy[m] = 1; mgidx[m] = pick;
      mlast[m] = pick; mwd[m] = 0;
    end
  endtask

  always begin
    @(posedge clk);
    for (int m = 0; m < 3; m++) mdl_step(m);
    #1;
    if (mdl_ok) begin
      for (int m = 0; m < 3; m++) begin
        chk($sformatf("m%0d grant_rd", m), 32'(g_rd[m]),
            mbusy[m] != 0 ? (32'd1 << mgidx[m]) : 32'd0);
        chk($sformatf("m%0d grant_idx", m), 32'(g_ix[m]),
            32'(mgidx[m]));
        chk($sformatf("m%0d busy", m), 32'(g_bz[m]),
            32'(mbusy[m]));
`ifdef AXIL_ARB_RD_WATCHDOG_EN
        chk($sformatf("m%0d timeout_err", m), 32'(to_o[m]),
            32'(mto[m]));
`endif
      end
    end
  end

  logic [3:0] exp1 [8] = '{4'h2, 4'h4, 4'h8, 4'h1,
                           4'h2, 4'h4, 4'h8, 4'h1};
  logic [3:0] exp2 [8] = '{4'h2, 4'h4, 4'h4, 4'h4,
                           4'h8, 4'h1, 4'h1, 4'h2};
  logic [3:0] fr [12] = '{4'h9, 4'h9, 4'h6, 4'h6, 4'h0, 4'h8,
                          4'h8, 4'h3, 4'hF, 4'h5, 4'h5, 4'hA};
  logic       fv [12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                          1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    rst = 1'b1; req = 4'h0; wt = 16'h1302;
    rvalid = 1'b0; rready = 4'h0;
    @(negedge clk);
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("rst m%0d grant", m), 32'(g_rd[m]), 0);
      chk($sformatf("rst m%0d idx", m), 32'(g_ix[m]), 0);
      chk($sformatf("rst m%0d busy", m), 32'(g_bz[m]), 0);
    end
    @(negedge clk);
    rst = 1'b0; req = 4'hF; rvalid = 1'b1; rready = 4'hF;

    for (int g = 0; g < 8; g++) begin
      @(negedge clk);
      chk($sformatf("seq m0 g%0d", g), 32'(g_rd[0]), 32'h1);
      chk($sformatf("seq m1 g%0d", g), 32'(g_rd[1]),
          32'(exp1[g]));
      chk($sformatf("seq m2 g%0d", g), 32'(g_rd[2]),
          32'(exp2[g]));
      @(negedge clk);
      chk($sformatf("gap m1 g%0d", g), 32'(g_rd[1]), 0);
      chk($sformatf("gap m2 g%0d", g), 32'(g_rd[2]), 0);
    end

    req = 4'hA; rvalid = 1'b0;
    @(negedge clk);
    chk("fix first", 32'(g_rd[0]), 32'h2);
    req = 4'h1;
    @(negedge clk);
    chk("fix hold req", 32'(g_rd[0]), 32'h2);
    rvalid = 1'b1; rready = 4'h0;
    @(negedge clk);
    chk("fix hold rdy", 32'(g_rd[0]), 32'h2);
    rready = 4'h2; req = 4'hA;
    @(negedge clk);
    chk("fix idle", 32'(g_rd[0]), 0);
    chk("fix idle busy", 32'(g_bz[0]), 0);
    @(negedge clk);
    chk("fix again", 32'(g_rd[0]), 32'h2);
    rready = 4'hF;

    @(negedge clk);
    rst = 1'b1; req = 4'h0; wt = 16'h0004;
    @(negedge clk);
    chk("wrr rst", 32'(g_rd[2]), 0);
    rst = 1'b0; req = 4'h1;
    @(negedge clk);
    chk("wrr m0", 32'(g_rd[2]), 32'h1);
    chk("rr m0", 32'(g_rd[1]), 32'h1);
    req = 4'h4;
    @(negedge clk);
    chk("wrr gap", 32'(g_rd[2]), 0);
    @(negedge clk);
    chk("wrr drop m2", 32'(g_rd[2]), 32'h4);
    chk("rr m2", 32'(g_rd[1]), 32'h4);

    rst = 1'b1; rvalid = 1'b0;
    @(negedge clk);
    chk("midrst m2 grant", 32'(g_rd[2]), 0);
    chk("midrst m2 busy", 32'(g_bz[2]), 0);
    chk("midrst m1 grant", 32'(g_rd[1]), 0);
    rst = 1'b0; req = 4'hF;
    @(negedge clk);
    chk("postrst m2", 32'(g_rd[2]), 32'h2);
    chk("postrst m1", 32'(g_rd[1]), 32'h2);

    repeat (8) @(negedge clk);
`ifdef AXIL_ARB_RD_WATCHDOG_EN
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("wd m%0d pulse", m), 32'(to_o[m]), 1);
      chk($sformatf("wd m%0d grant", m), 32'(g_rd[m]), 0);
    end
    @(negedge clk);
    chk("wd m2 pulse end", 32'(to_o[2]), 0);
`else
    chk("wait m2", 32'(g_rd[2]), 32'h2);
    chk("wait m1 busy", 32'(g_bz[1]), 1);
`endif

    wt = 16'h0320;
    for (int i = 0; i < 12; i++) begin
      req = fr[i]; rvalid = fv[i];
      @(negedge clk);
    end
    rvalid = 1'b1; req = 4'h0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
